// File: rtl/leg_pkg.sv
// -----------------------------------------------------------------------------
// leg_pkg
// Shared definitions for the decoder, the dispatch stage and the reservation
// stations.
//   RS_* codes  : reservation station selector carried alongside each micro-op
//   uop_t       : packed micro-op layout (UOP_W bits, operation in the MSBs)
//   rs_code_ok  : true when a station code names a real station (1..num_rs)
// -----------------------------------------------------------------------------
package leg_pkg;

    localparam int UOP_W     = 46;
    localparam int RS_CODE_W = 4;

    typedef enum logic [RS_CODE_W-1:0] {
        RS_NONE   = 4'd0,
        RS_ALU    = 4'd1,
        RS_MULDIV = 4'd2,
        RS_BRANCH = 4'd3,
        RS_LDST   = 4'd4
    } rs_code_t;

    typedef struct packed {
        logic [5:0]  operation;
        logic [4:0]  register_target;
        logic [4:0]  register_1;
        logic [4:0]  register_2;
        logic [15:0] immediate;
        logic [5:0]  alu_fn;
        logic        has_register_1;
        logic        has_register_2;
        logic        has_target;
    } uop_t;

    // Code 0 means "no station"; codes above the station count are treated
    // the same way, so the micro-op is discarded rather than stored.
    function automatic logic rs_code_ok(input logic [RS_CODE_W-1:0] code,
                                        input int num_rs);
        return (code != '0) && (int'(code) <= num_rs);
    endfunction

endpackage

// File: rtl/rs_credit_counter.sv
// -----------------------------------------------------------------------------
// rs_credit_counter
// Free-entry credit counter for a single reservation station.
//   clk, rst_n  : clock, asynchronous active-low reset (credit -> RS_DEPTH)
//   credit_ret  : station freed one entry this cycle
//   consume     : dispatch stage sent one micro-op to this station this cycle
//   has_credit  : at least one free entry is available (pre-edge value)
//   err         : sticky; a return arrived while already at RS_DEPTH
// Return and consume in the same cycle cancel out.
// -----------------------------------------------------------------------------
module rs_credit_counter #(
    parameter int RS_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic credit_ret,
    input  logic consume,
    output logic has_credit,
    output logic err
);

    localparam int CRW = $clog2(RS_DEPTH + 1);
    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(RS_DEPTH);

    logic [CRW-1:0] credit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= CREDIT_MAX;
            err    <= 1'b0;
        end else begin
            case ({credit_ret, consume})
                2'b10: begin
                    // A return with nothing outstanding saturates and flags.
                    if (credit == CREDIT_MAX) err <= 1'b1;
                    else                      credit <= credit + CRW'(1);
                end
                2'b01: begin
                    if (credit != '0) credit <= credit - CRW'(1);
                end
                default: ;
            endcase
        end
    end

    assign has_credit = (credit != '0);

endmodule

// File: rtl/rs_dispatch.sv
// -----------------------------------------------------------------------------
// rs_dispatch
// In-order dispatch between the decoder and NUM_RS reservation stations.
// Decoded micro-ops are queued in a DEPTH-entry FIFO (no-ops dropped) and the
// head is issued only when its target station holds a free-entry credit.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : discard all queued micro-ops (mispredict)
//   in_valid/ready : decoder handshake
//   in_rs_station  : target station code (0 = none)
//   in_is_noop     : decoder no-op flag
//   in_uop         : packed micro-op
//   out_valid      : dispatch happens at the coming edge
//   out_rs_sel     : one-hot station select, bit i = station i+1
//   out_uop        : head micro-op
//   credit_return  : bit i = station i+1 freed one entry
//   fifo_count     : FIFO occupancy
//   noop_count     : dropped micro-op counter (wraps)
//   credit_err     : sticky over-return flag (any station)
//
// Handshake: a transfer on the input side happens on an edge where both
// in_valid and in_ready are high; in_ready depends only on registered state
// and flush, never on in_valid. The output side has no ready: out_valid high
// means the head is consumed at that edge, the station having been
// pre-cleared by its credit.
// -----------------------------------------------------------------------------
module rs_dispatch
    import leg_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int NUM_RS   = 4,
    parameter int RS_DEPTH = 2,
    parameter int UOP_W    = leg_pkg::UOP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_rs_station,
    input  logic                     in_is_noop,
    input  logic [UOP_W-1:0]         in_uop,
    output logic                     out_valid,
    output logic [NUM_RS-1:0]        out_rs_sel,
    output logic [UOP_W-1:0]         out_uop,
    input  logic [NUM_RS-1:0]        credit_return,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              noop_count,
    output logic                     credit_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [RS_CODE_W-1:0] st_mem  [DEPTH];
    logic [UOP_W-1:0]     uop_mem [DEPTH];

    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [CW-1:0]        count;
    logic [15:0]          noops;

    logic [RS_CODE_W-1:0] head_station;
    logic [NUM_RS-1:0]    head_sel;
    logic                 head_has_credit;
    logic [NUM_RS-1:0]    has_credit;
    logic [NUM_RS-1:0]    station_err;

    logic                 accept;
    logic                 drop;
    logic                 store;

    // Input side
    assign in_ready = (count < DEPTH_C) && !flush;
    assign accept   = in_valid && in_ready;
    assign drop     = in_is_noop || !rs_code_ok(in_rs_station, NUM_RS);
    assign store    = accept && !drop;

    // Head decode: only valid station codes are ever written, so an
    // unmatched code can only appear when the FIFO is empty.
    assign head_station = st_mem[head];

    always_comb begin
        head_sel        = '0;
        head_has_credit = 1'b0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (head_station == RS_CODE_W'(i + 1)) begin
                head_sel[i]     = 1'b1;
                head_has_credit = has_credit[i];
            end
        end
    end

    assign out_valid  = (count != '0) && head_has_credit && !flush;
    assign out_rs_sel = out_valid ? head_sel : '0;
    assign out_uop    = uop_mem[head];

    // FIFO control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            noops <= '0;
        end else if (flush) begin
            // accept and dispatch are already suppressed while flushing
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store)     tail <= tail + PW'(1);
            if (out_valid) head <= head + PW'(1);
            case ({store, out_valid})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (accept && drop) noops <= noops + 16'd1;
        end
    end

    // FIFO storage needs no reset; occupancy says which slots are live.
    always_ff @(posedge clk) begin
        if (store) begin
            st_mem[tail]  <= in_rs_station;
            uop_mem[tail] <= in_uop;
        end
    end

    // One credit counter per station
    for (genvar g = 0; g < NUM_RS; g++) begin : g_credit
        rs_credit_counter #(
            .RS_DEPTH (RS_DEPTH)
        ) u_credit (
            .clk        (clk),
            .rst_n      (rst_n),
            .credit_ret (credit_return[g]),
            .consume    (out_rs_sel[g]),
            .has_credit (has_credit[g]),
            .err        (station_err[g])
        );
    end

    assign fifo_count = count;
    assign noop_count = noops;
    assign credit_err = |station_err;

endmodule

// File: tb/tb_rs_dispatch.sv
module tb_rs_dispatch;
    import leg_pkg::*;

    localparam int DEPTH    = 4;
    localparam int NUM_RS   = 4;
    localparam int RS_DEPTH = 2;

    // ---------------- clock / reset / DUT ----------------
    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_rs_station;
    logic              in_is_noop;
    logic [UOP_W-1:0]  in_uop;
    logic              out_valid;
    logic [NUM_RS-1:0] out_rs_sel;
    logic [UOP_W-1:0]  out_uop;
    logic [NUM_RS-1:0] credit_return;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0]       noop_count;
    logic              credit_err;

    rs_dispatch #(
        .DEPTH    (DEPTH),
        .NUM_RS   (NUM_RS),
        .RS_DEPTH (RS_DEPTH),
        .UOP_W    (UOP_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rs_station (in_rs_station),
        .in_is_noop    (in_is_noop),
        .in_uop        (in_uop),
        .out_valid     (out_valid),
        .out_rs_sel    (out_rs_sel),
        .out_uop       (out_uop),
        .credit_return (credit_return),
        .fifo_count    (fifo_count),
        .noop_count    (noop_count),
        .credit_err    (credit_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Queue of pending micro-ops plus plain integer credits.
    logic [3:0]       mq_st[$];
    logic [UOP_W-1:0] exp_q[$];
    int               mcred[NUM_RS];
    logic [15:0]      mnoop;
    logic             merr;

    task automatic model_reset();
        mq_st.delete();
        exp_q.delete();
        for (int i = 0; i < NUM_RS; i++) mcred[i] = RS_DEPTH;
        mnoop = '0;
        merr  = 1'b0;
    endtask

    function automatic logic model_ready();
        return (mq_st.size() < DEPTH) && !flush;
    endfunction

    function automatic logic model_valid();
        if (flush || mq_st.size() == 0) return 1'b0;
        return mcred[int'(mq_st[0]) - 1] > 0;
    endfunction

    function automatic logic [3:0] model_sel();
        if (!model_valid()) return 4'b0000;
        return 4'b0001 << (int'(mq_st[0]) - 1);
    endfunction

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        logic dv;
        int   hs;
        int   sz;
        int   n;
        dv = model_valid();
        hs = (mq_st.size() > 0) ? int'(mq_st[0]) : 0;
        sz = mq_st.size();
        if (flush) begin
            mq_st.delete();
            exp_q.delete();
        end else begin
            if (dv) begin
                void'(mq_st.pop_front());
                void'(exp_q.pop_front());
            end
            if (in_valid && sz < DEPTH) begin
                if (in_is_noop || in_rs_station == 0 || int'(in_rs_station) > NUM_RS)
                    mnoop = mnoop + 16'd1;
                else begin
                    mq_st.push_back(in_rs_station);
                    exp_q.push_back(in_uop);
                end
            end
        end
        for (int i = 0; i < NUM_RS; i++) begin
            n = mcred[i] + int'(credit_return[i]) - ((dv && hs == i + 1) ? 1 : 0);
            if (n > RS_DEPTH) begin
                merr = 1'b1;
                n    = RS_DEPTH;
            end
            mcred[i] = n;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic fl, input logic vld, input logic [3:0] st,
                         input logic nop, input logic [3:0] cret);
        flush         = fl;
        in_valid      = vld;
        in_rs_station = st;
        in_is_noop    = nop;
        credit_return = cret;
        in_uop        = {$urandom(), $urandom()};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rs_sel", out_rs_sel, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_noop_count", noop_count, 0);
        chk("rst_credit_err", credit_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Full model comparison for one cycle, then advance.
    task automatic check_cycle();
        @(negedge clk);
        chk("in_ready", in_ready, model_ready());
        chk("out_valid", out_valid, model_valid());
        chk("out_rs_sel", out_rs_sel, model_sel());
        if (model_valid()) chk("out_uop", out_uop, exp_q[0]);
        chk("fifo_count", fifo_count, mq_st.size());
        chk("noop_count", noop_count, mnoop);
        chk("credit_err", credit_err, merr);
        model_step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        fl;
        logic        vld;
        logic [3:0]  st;
        logic        nop;
        logic [3:0]  cret;
        logic        e_rdy;
        logic        e_vld;
        logic [3:0]  e_sel;
        logic [2:0]  e_cnt;
        logic [15:0] e_noop;
        logic        e_err;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic fl, input logic vld, input logic [3:0] st,
                       input logic nop, input logic [3:0] cret,
                       input logic e_rdy, input logic e_vld, input logic [3:0] e_sel,
                       input logic [2:0] e_cnt, input logic [15:0] e_noop,
                       input logic e_err);
        vec_t v;
        v.fl = fl; v.vld = vld; v.st = st; v.nop = nop; v.cret = cret;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_sel = e_sel; v.e_cnt = e_cnt;
        v.e_noop = e_noop; v.e_err = e_err;
        tv.push_back(v);
    endtask

    task automatic build_table();
        // three ALU ops, two credits: third stalls until a return
        add(0,1,1,0,4'h0, 1,0,4'h0,0, 0,0);
        add(0,1,1,0,4'h0, 1,1,4'h1,1, 0,0);
        add(0,1,1,0,4'h0, 1,1,4'h1,1, 0,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,1, 0,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,1, 0,0);
        add(0,0,0,0,4'h1, 1,0,4'h0,1, 0,0);
        add(0,0,0,0,4'h0, 1,1,4'h1,1, 0,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,0, 0,0);
        // drain station 4, then load blocks a younger ALU op
        add(0,1,4,0,4'h0, 1,0,4'h0,0, 0,0);
        add(0,1,4,0,4'h0, 1,1,4'h8,1, 0,0);
        add(0,0,0,0,4'h0, 1,1,4'h8,1, 0,0);
        add(0,1,4,0,4'h1, 1,0,4'h0,0, 0,0);
        add(0,1,1,0,4'h0, 1,0,4'h0,1, 0,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,2, 0,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,2, 0,0);
        add(0,0,0,0,4'h8, 1,0,4'h0,2, 0,0);
        add(0,0,0,0,4'h0, 1,1,4'h8,2, 0,0);
        add(0,0,0,0,4'h0, 1,1,4'h1,1, 0,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,0, 0,0);
        // dropped micro-ops
        for (int i = 0; i < 5; i++) add(0,1,1,1,4'h0, 1,0,4'h0,0, 16'(i),0);
        add(0,1,0,0,4'h0, 1,0,4'h0,0, 5,0);
        add(0,1,7,0,4'h0, 1,0,4'h0,0, 6,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,0, 7,0);
        // fill with station 1 at zero credits
        add(0,1,1,0,4'h0, 1,0,4'h0,0, 7,0);
        add(0,1,1,0,4'h0, 1,0,4'h0,1, 7,0);
        add(0,1,1,0,4'h0, 1,0,4'h0,2, 7,0);
        add(0,1,1,0,4'h0, 1,0,4'h0,3, 7,0);
        add(0,1,1,0,4'h0, 0,0,4'h0,4, 7,0);
        add(0,0,0,0,4'h1, 0,0,4'h0,4, 7,0);
        add(0,0,0,0,4'h0, 0,1,4'h1,4, 7,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,3, 7,0);
        // flush with dispatch and accept both pending
        add(0,0,0,0,4'h1, 1,0,4'h0,3, 7,0);
        add(1,1,2,0,4'h0, 0,0,4'h0,3, 7,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,0, 7,0);
        add(0,1,1,0,4'h0, 1,0,4'h0,0, 7,0);
        add(0,0,0,0,4'h0, 1,1,4'h1,1, 7,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,0, 7,0);
        // station 2: return+consume nets zero, over-return flags
        add(0,1,2,0,4'h0, 1,0,4'h0,0, 7,0);
        add(0,1,2,0,4'h0, 1,1,4'h2,1, 7,0);
        add(0,0,0,0,4'h2, 1,1,4'h2,1, 7,0);
        add(0,1,2,0,4'h0, 1,0,4'h0,0, 7,0);
        add(0,0,0,0,4'h0, 1,1,4'h2,1, 7,0);
        add(0,1,2,0,4'h0, 1,0,4'h0,0, 7,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,1, 7,0);
        add(0,0,0,0,4'h2, 1,0,4'h0,1, 7,0);
        add(0,0,0,0,4'h2, 1,1,4'h2,1, 7,0);
        add(0,0,0,0,4'h2, 1,0,4'h0,0, 7,0);
        add(0,0,0,0,4'h2, 1,0,4'h0,0, 7,0);
        add(0,0,0,0,4'h0, 1,0,4'h0,0, 7,1);
        add(0,0,0,0,4'h0, 1,0,4'h0,0, 7,1);
        add(0,1,2,0,4'h0, 1,0,4'h0,0, 7,1);
        add(0,1,2,0,4'h0, 1,1,4'h2,1, 7,1);
        add(0,0,0,0,4'h0, 1,1,4'h2,1, 7,1);
        add(0,1,2,0,4'h0, 1,0,4'h0,0, 7,1);
        add(0,0,0,0,4'h0, 1,0,4'h0,1, 7,1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        build_table();
        do_reset();

        // directed table
        foreach (tv[k]) begin
            drive(tv[k].fl, tv[k].vld, tv[k].st, tv[k].nop, tv[k].cret);
            @(negedge clk);
            chk($sformatf("v%0d_in_ready", k), in_ready, tv[k].e_rdy);
            chk($sformatf("v%0d_out_valid", k), out_valid, tv[k].e_vld);
            chk($sformatf("v%0d_out_rs_sel", k), out_rs_sel, tv[k].e_sel);
            chk($sformatf("v%0d_fifo_count", k), fifo_count, tv[k].e_cnt);
            chk($sformatf("v%0d_noop_count", k), noop_count, tv[k].e_noop);
            chk($sformatf("v%0d_credit_err", k), credit_err, tv[k].e_err);
            if (tv[k].e_vld && exp_q.size() > 0)
                chk($sformatf("v%0d_out_uop", k), out_uop, exp_q[0]);
            model_step();
            @(posedge clk);
            #1;
        end

        // randomized phase against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] st;
            logic [3:0] cret;
            int r;
            r  = $urandom_range(0, 15);
            st = (r < 12) ? 4'((r % 4) + 1) : 4'($urandom_range(0, 15));
            for (int i = 0; i < NUM_RS; i++)
                cret[i] = (mcred[i] < RS_DEPTH && $urandom_range(0, 2) == 0) ||
                          ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 31) == 0, $urandom_range(0, 9) < 7, st,
                  $urandom_range(0, 7) == 0, cret);
            check_cycle();
        end

        // reset asserted while a dispatch is pending clears at once
        do_reset();
        drive(0, 1, 3, 0, 0);
        check_cycle();
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_reset_out_valid", out_valid, model_valid());
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_rs_sel", out_rs_sel, 0);
        chk("async_rst_fifo_count", fifo_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 3, 0, 0);
            check_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0);
            check_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
